// File: rtl/ifmap_skew_feeder.sv
// ifmap_skew_feeder: accepts one ifmap column vector per cycle and fans it
// out to the systolic array rows. Row r sees lane r delayed by r extra
// cycles, which forms the diagonal wavefront. The block also tracks tile
// boundaries, drains the skew after the last vector, and reports tile
// completion and tile length.
//
// Optional build macro: IFEED_ZERO_BUBBLE_EN
//   defined   - I_in lane r reads 0 in every cycle where I_en[r] is 0
//   undefined - I_in lane r holds its last valid element through bubbles,
//               which keeps the array-side data bus from toggling
//
// FSM:
//   state  | meaning
//   IDLE   | between tiles, ready for a tile's first vector, vec_cnt = 0
//   STREAM | inside a tile, counting accepted vectors
//   FLUSH  | last vector taken, waiting ROWS-1 cycles for the skew to drain
module ifmap_skew_feeder #(
  parameter int ROWS           = 4,
  parameter int IFMAP_BITWIDTH = 16,
  parameter int MAX_K          = 256,
  localparam int CW            = $clog2(MAX_K + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [ROWS*IFMAP_BITWIDTH-1:0] s_data,
  input  logic                           s_last,
  output logic [ROWS-1:0]                I_en,
  output logic [ROWS*IFMAP_BITWIDTH-1:0] I_in,
  output logic                           tile_done,
  output logic [CW-1:0]                  tile_len,
  output logic                           err_overflow
);

  localparam int W = IFMAP_BITWIDTH;
  // flush_cnt only has to hold ROWS-1; keep at least one bit for ROWS==1
  localparam int FW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_K);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(ROWS - 1);
  localparam logic [FW-1:0] FLUSH_ONE = FW'(1);
  // with one row there is no skew to drain, so the tile ends on the last accept
  localparam bit SINGLE_ROW = (ROWS == 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] vec_cnt;
  logic [CW-1:0] vec_cnt_inc;
  logic [FW-1:0] flush_cnt;
  logic          accept;
  logic          at_max;

  // ready depends on state alone so upstream can never form a loop through valid
  assign s_ready = (state != FLUSH);
  assign accept  = s_valid && s_ready;
  assign at_max  = (vec_cnt == CNT_MAX);

  // saturating increment; an overlong tile pins the count at MAX_K
  always_comb begin
    vec_cnt_inc = vec_cnt;
    if (!at_max) begin
      vec_cnt_inc = vec_cnt + CW'(1);
    end
  end

  // Per-lane skew chains. Lane r holds r+1 stages of {en,data}, and its last
  // stage drives row r. Stage 0 captures every edge, so a cycle with no
  // accept moves through the chain as a bubble. The array gives no
  // backpressure, so these chains never stall.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [r:0]   en_q;
    logic [W-1:0] data_q [0:r];

    // shift {en,data} one stage per cycle; data handling on bubbles depends on the build
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        en_q <= '0;
        for (int k = 0; k <= r; k++) begin
          data_q[k] <= '0;
        end
      end else begin
        en_q[0] <= accept;
`ifdef IFEED_ZERO_BUBBLE_EN
        data_q[0] <= accept ? s_data[r*W +: W] : '0;
`else
        if (accept) begin
          data_q[0] <= s_data[r*W +: W];
        end
`endif
        for (int k = 1; k <= r; k++) begin
          en_q[k] <= en_q[k-1];
`ifdef IFEED_ZERO_BUBBLE_EN
          data_q[k] <= en_q[k-1] ? data_q[k-1] : '0;
`else
          if (en_q[k-1]) begin
            data_q[k] <= data_q[k-1];
          end
`endif
        end
      end
    end

    assign I_en[r]         = en_q[r];
    assign I_in[r*W +: W]  = data_q[r];
  end

  // Tile FSM with registered tile_done, tile_len and sticky err_overflow.
  // tile_done fires on the edge that also moves the last vector onto row
  // ROWS-1, so the pulse lines up with that row's final I_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      vec_cnt      <= '0;
      flush_cnt    <= '0;
      tile_done    <= 1'b0;
      tile_len     <= '0;
      err_overflow <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        IDLE, STREAM: begin
          if (accept) begin
            if (!s_last && at_max) begin
              err_overflow <= 1'b1;
            end
            if (s_last) begin
              if (SINGLE_ROW) begin
                tile_done <= 1'b1;
                tile_len  <= vec_cnt_inc;
                vec_cnt   <= '0;
                state     <= IDLE;
              end else begin
                vec_cnt   <= vec_cnt_inc;
                flush_cnt <= FLUSH_INIT;
                state     <= FLUSH;
              end
            end else begin
              vec_cnt <= vec_cnt_inc;
              state   <= STREAM;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - FW'(1);
          if (flush_cnt == FLUSH_ONE) begin
            tile_done <= 1'b1;
            tile_len  <= vec_cnt;
            vec_cnt   <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          vec_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_skew_feeder.sv
// Directed bench for ifmap_skew_feeder (ROWS=4, 16-bit lanes). A second
// instance with MAX_K=4 covers the overflow case. Build with or without
// IFEED_ZERO_BUBBLE_EN; the expected idle-lane data follows the build.
module tb_ifmap_skew_feeder;

  localparam int ROWS = 4;
  localparam int W    = 16;
  localparam int CW   = $clog2(256 + 1);
  localparam int CWO  = $clog2(4 + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid, s_last, s_ready;
  logic [ROWS*W-1:0] s_data;
  logic [ROWS-1:0]   I_en;
  logic [ROWS*W-1:0] I_in;
  logic              tile_done, err_overflow;
  logic [CW-1:0]     tile_len;

  logic              ov_valid, ov_last, ov_ready;
  logic [ROWS*W-1:0] ov_data;
  logic [ROWS-1:0]   ov_en;
  logic [ROWS*W-1:0] ov_in;
  logic              ov_done, ov_err;
  logic [CWO-1:0]    ov_len;

  int n_cmp = 0;
  int n_err = 0;

  bit          sv [0:15];
  bit          sl [0:15];
  logic [W-1:0] held [0:ROWS-1];

  always #5 clk = ~clk;

  ifmap_skew_feeder #(.ROWS(ROWS), .IFMAP_BITWIDTH(W), .MAX_K(256)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .I_en(I_en), .I_in(I_in), .tile_done(tile_done),
    .tile_len(tile_len), .err_overflow(err_overflow)
  );

  ifmap_skew_feeder #(.ROWS(ROWS), .IFMAP_BITWIDTH(W), .MAX_K(4)) dut_ov (
    .clk(clk), .rst(rst), .s_valid(ov_valid), .s_ready(ov_ready), .s_data(ov_data),
    .s_last(ov_last), .I_en(ov_en), .I_in(ov_in), .tile_done(ov_done),
    .tile_len(ov_len), .err_overflow(ov_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] val(input int base, input int e, input int r);
    return W'(base + 16*e + r);
  endfunction

  function automatic logic [ROWS*W-1:0] vec(input int base, input int e);
    logic [ROWS*W-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*W +: W] = val(base, e, r);
    return v;
  endfunction

  task automatic clear_tab();
    for (int i = 0; i < 16; i++) begin
      sv[i] = 1'b0;
      sl[i] = 1'b0;
    end
  endtask

  task automatic drive(input int e, input int n_edges, input int base);
    if (e < n_edges && sv[e]) begin
      s_valid = 1'b1;
      s_last  = sl[e];
      s_data  = vec(base, e);
    end else begin
      s_valid = 1'b0;
      s_last  = 1'b1;
      s_data  = {ROWS{16'hBEEF}};
    end
  endtask

  // cycle c = the cycle after edge c of the sequence; row r shows edge c-r
  task automatic run_seq(input string name, input int n_edges, input int n_cyc,
                         input int base, input int exp_len);
    logic [ROWS-1:0]   en_exp;
    logic [ROWS*W-1:0] in_exp;
    bit                done_exp, rdy_exp;
    int                e;
    chk({name, "_ready_pre"}, 64'(s_ready), 64'd1);
    drive(0, n_edges, base);
    for (int c = 0; c < n_cyc; c++) begin
      tick();
      drive(c + 1, n_edges, base);
      done_exp = 1'b0;
      rdy_exp  = 1'b1;
      for (int el = 0; el < n_edges; el++) begin
        if (sv[el] && sl[el]) begin
          if (c == el + ROWS - 1) done_exp = 1'b1;
          if (c >= el && c <= el + ROWS - 2) rdy_exp = 1'b0;
        end
      end
      for (int r = 0; r < ROWS; r++) begin
        e = c - r;
        en_exp[r] = (e >= 0 && e < n_edges) ? sv[e] : 1'b0;
        if (en_exp[r]) held[r] = val(base, e, r);
`ifdef IFEED_ZERO_BUBBLE_EN
        in_exp[r*W +: W] = en_exp[r] ? held[r] : '0;
`else
        in_exp[r*W +: W] = held[r];
`endif
      end
      chk($sformatf("%s_en_c%0d", name, c), 64'(I_en), 64'(en_exp));
      chk($sformatf("%s_in_c%0d", name, c), 64'(I_in), 64'(in_exp));
      chk($sformatf("%s_done_c%0d", name, c), 64'(tile_done), 64'(done_exp));
      chk($sformatf("%s_ready_c%0d", name, c), 64'(s_ready), 64'(rdy_exp));
      if (done_exp) chk($sformatf("%s_len_c%0d", name, c), 64'(tile_len), 64'(exp_len));
    end
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    ov_valid = 1'b0; ov_last = 1'b0; ov_data = '0;
    for (int r = 0; r < ROWS; r++) held[r] = '0;
    #12;
    chk("rst_en", 64'(I_en), 64'd0);
    chk("rst_in", 64'(I_in), 64'd0);
    chk("rst_done", 64'(tile_done), 64'd0);
    chk("rst_len", 64'(tile_len), 64'd0);
    chk("rst_err", 64'(err_overflow), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd1);
    rst = 1'b0;
    tick();

    // single vector {1,2,3,4}, last
    clear_tab();
    sv[0] = 1; sl[0] = 1;
    run_seq("single", 1, 6, 1, 1);

    // 8 back-to-back vectors, lane value 16*k+r
    clear_tab();
    for (int k = 0; k < 8; k++) sv[k] = 1;
    sl[7] = 1;
    run_seq("burst8", 8, 12, 0, 8);

    // tile of 3 with one idle cycle between the first and second vector
    clear_tab();
    sv[0] = 1; sv[2] = 1; sv[3] = 1; sl[3] = 1;
    run_seq("bubble", 4, 8, 'h100, 3);

    // second tile offered in the first tile's tile_done cycle
    clear_tab();
    sv[0] = 1; sv[1] = 1; sl[1] = 1;
    sv[5] = 1; sv[6] = 1; sl[6] = 1;
    run_seq("b2b", 7, 11, 'h200, 2);
    chk("b2b_err_clear", 64'(err_overflow), 64'd0);

    // overflow on the MAX_K=4 instance: 6 vectors, last on the 6th
    ov_valid = 1'b1; ov_last = 1'b0; ov_data = vec('h300, 0);
    for (int c = 0; c < 10; c++) begin
      logic [ROWS-1:0] oe;
      tick();
      if (c + 1 < 6) begin
        ov_valid = 1'b1;
        ov_last  = (c + 1 == 5);
        ov_data  = vec('h300, c + 1);
      end else begin
        ov_valid = 1'b0;
        ov_last  = 1'b0;
      end
      for (int r = 0; r < ROWS; r++) oe[r] = (c - r >= 0 && c - r < 6);
      chk($sformatf("ovf_en_c%0d", c), 64'(ov_en), 64'(oe));
      chk($sformatf("ovf_err_c%0d", c), 64'(ov_err), 64'(c >= 4));
      chk($sformatf("ovf_done_c%0d", c), 64'(ov_done), 64'(c == 8));
      if (oe[3]) chk($sformatf("ovf_in3_c%0d", c), 64'(ov_in[3*W +: W]), 64'(val('h300, c - 3, 3)));
      if (c == 8) chk("ovf_len", 64'(ov_len), 64'd4);
    end

    // async reset in the middle of FLUSH
    s_valid = 1'b1; s_last = 1'b1; s_data = vec('h400, 0);
    tick();
    s_valid = 1'b0;
    tick();
    chk("rstf_ready_flush", 64'(s_ready), 64'd0);
    #3 rst = 1'b1;
    #1;
    chk("rstf_en", 64'(I_en), 64'd0);
    chk("rstf_in", 64'(I_in), 64'd0);
    chk("rstf_ready", 64'(s_ready), 64'd1);
    chk("rstf_ovf_err", 64'(ov_err), 64'd0);
    for (int r = 0; r < ROWS; r++) held[r] = '0;
    tick();
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("rstf_nodone_c%0d", c), 64'(tile_done), 64'd0);
      chk($sformatf("rstf_noen_c%0d", c), 64'(I_en), 64'd0);
    end
    clear_tab();
    sv[0] = 1; sv[1] = 1; sl[1] = 1;
    run_seq("post_rst", 2, 7, 'h500, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
